// File: rtl/sum_onehot_monitor.sv
// Run-time monitor for an operand pair: registers a + 1 and flags range, equality
// and one-hot violations as single-cycle pulses with sticky bits and saturating counters.
module sum_onehot_monitor #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_SUM = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              err_sum,
    output logic              err_neq,
    output logic              err_onehot,
    output logic              err_any,
    output logic [2:0]        sticky,
    output logic [CNT_W-1:0]  cnt_sum,
    output logic [CNT_W-1:0]  cnt_neq,
    output logic [CNT_W-1:0]  cnt_onehot
);

    localparam int NUM_CHK = 3;

    logic [DATA_W-1:0]  sum_reg;
    logic               sum_vld_reg;
    logic               err_any_reg;
    logic               a_onehot;
    logic               sum_over;
    logic [NUM_CHK-1:0] pulse_next;
    logic [NUM_CHK-1:0] pulse_q;
    logic [NUM_CHK-1:0] sticky_q;
    logic [CNT_W-1:0]   cnt_q [NUM_CHK];

    // Widen both sides so a MAX_SUM beyond the sum range simply never trips.
    assign sum_over = (64'(sum_reg) >= 64'(MAX_SUM));
    assign a_onehot = (a != '0) && ((a & (a - DATA_W'(1))) == '0);

    always_comb begin
        pulse_next    = '0;
        pulse_next[0] = en & sum_vld_reg & sum_over;
        pulse_next[1] = en & (a == b);
        pulse_next[2] = en & ~a_onehot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg     <= '0;
            sum_vld_reg <= 1'b0;
            err_any_reg <= 1'b0;
        end else begin
            sum_reg     <= a + DATA_W'(1);
            sum_vld_reg <= 1'b1;
            err_any_reg <= |pulse_next;
        end
    end

    // Bit order of every per-check vector: 0 = sum, 1 = neq, 2 = onehot.
    generate
        for (genvar gi = 0; gi < NUM_CHK; gi++) begin : g_chk
            logic             pulse_reg;
            logic             sticky_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pulse_reg  <= 1'b0;
                    sticky_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    pulse_reg <= pulse_next[gi];
                    if (clr) begin
                        sticky_reg <= pulse_next[gi];
                        cnt_reg    <= CNT_W'(pulse_next[gi]);
                    end else if (pulse_next[gi]) begin
                        sticky_reg <= 1'b1;
                        if (cnt_reg != '1) begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
            end

            assign pulse_q[gi]  = pulse_reg;
            assign sticky_q[gi] = sticky_reg;
            assign cnt_q[gi]    = cnt_reg;
        end
    endgenerate

    assign sum        = sum_reg;
    assign err_sum    = pulse_q[0];
    assign err_neq    = pulse_q[1];
    assign err_onehot = pulse_q[2];
    assign err_any    = err_any_reg;
    assign sticky     = sticky_q;
    assign cnt_sum    = cnt_q[0];
    assign cnt_neq    = cnt_q[1];
    assign cnt_onehot = cnt_q[2];

endmodule

// File: tb/tb_sum_onehot_monitor.sv
// Self-checking bench for sum_onehot_monitor: table-driven vectors through a
// scoreboard queue, plus hand-written reset and counter-saturation sequences.
module tb_sum_onehot_monitor;

    localparam int DATA_W  = 8;
    localparam int MAX_SUM = 5;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sum;
    logic              err_sum;
    logic              err_neq;
    logic              err_onehot;
    logic              err_any;
    logic [2:0]        sticky;
    logic [CNT_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_neq;
    logic [CNT_W-1:0]  cnt_onehot;

    sum_onehot_monitor #(
        .DATA_W (DATA_W),
        .MAX_SUM(MAX_SUM),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .err_sum   (err_sum),
        .err_neq   (err_neq),
        .err_onehot(err_onehot),
        .err_any   (err_any),
        .sticky    (sticky),
        .cnt_sum   (cnt_sum),
        .cnt_neq   (cnt_neq),
        .cnt_onehot(cnt_onehot)
    );

    always #5 clk = ~clk;

    // exp_err bit order: {onehot, neq, sum}
    typedef struct {
        logic              rst_n;
        logic              en;
        logic              clr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp_sum;
        logic [2:0]        exp_err;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] sum;
        logic [2:0]        err;
        logic [2:0]        sticky;
        logic [CNT_W-1:0]  cnt [3];
    } exp_t;

    exp_t             sb_q[$];
    logic [2:0]       m_sticky = '0;
    logic [CNT_W-1:0] m_cnt [3] = '{default: '0};
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_expected(input vec_t v);
        exp_t e;
        if (!v.rst_n) begin
            m_sticky = '0;
            for (int i = 0; i < 3; i++) m_cnt[i] = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (v.clr) begin
                    m_sticky[i] = v.exp_err[i];
                    m_cnt[i]    = v.exp_err[i] ? CNT_W'(1) : '0;
                end else if (v.exp_err[i]) begin
                    m_sticky[i] = 1'b1;
                    if (m_cnt[i] != {CNT_W{1'b1}}) m_cnt[i] = m_cnt[i] + 1'b1;
                end
            end
        end
        e.sum    = v.exp_sum;
        e.err    = v.exp_err;
        e.sticky = m_sticky;
        for (int i = 0; i < 3; i++) e.cnt[i] = m_cnt[i];
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs(input int idx);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
            return;
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d_sum", idx),        32'(sum),        32'(e.sum));
        check($sformatf("v%0d_err_sum", idx),    32'(err_sum),    32'(e.err[0]));
        check($sformatf("v%0d_err_neq", idx),    32'(err_neq),    32'(e.err[1]));
        check($sformatf("v%0d_err_onehot", idx), 32'(err_onehot), 32'(e.err[2]));
        check($sformatf("v%0d_err_any", idx),    32'(err_any),    32'(|e.err));
        check($sformatf("v%0d_sticky", idx),     32'(sticky),     32'(e.sticky));
        check($sformatf("v%0d_cnt_sum", idx),    32'(cnt_sum),    32'(e.cnt[0]));
        check($sformatf("v%0d_cnt_neq", idx),    32'(cnt_neq),    32'(e.cnt[1]));
        check($sformatf("v%0d_cnt_onehot", idx), 32'(cnt_onehot), 32'(e.cnt[2]));
        $display("vec %0d rst_n=%b en=%b clr=%b a=%h b=%h -> sum=%h err=%b%b%b any=%b sticky=%b cnt=%0d/%0d/%0d",
                 idx, rst_n, en, clr, a, b, sum, err_onehot, err_neq, err_sum, err_any,
                 sticky, cnt_sum, cnt_neq, cnt_onehot);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n = v.rst_n;
        en    = v.en;
        clr   = v.clr;
        a     = v.a;
        b     = v.b;
        push_expected(v);
        @(posedge clk);
        #1;
        compare_outputs(idx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"},        32'(sum),        32'd0);
        check({tag, "_err_any"},    32'(err_any),    32'd0);
        check({tag, "_err_bits"},   32'({err_onehot, err_neq, err_sum}), 32'd0);
        check({tag, "_sticky"},     32'(sticky),     32'd0);
        check({tag, "_cnt_sum"},    32'(cnt_sum),    32'd0);
        check({tag, "_cnt_neq"},    32'(cnt_neq),    32'd0);
        check({tag, "_cnt_onehot"}, 32'(cnt_onehot), 32'd0);
        $display("%s: sum=%h err_any=%b sticky=%b cnt=%0d/%0d/%0d",
                 tag, sum, err_any, sticky, cnt_sum, cnt_neq, cnt_onehot);
    endtask

    vec_t vecs [18];

    initial begin
        //            rst en clr a      b      sum    err{oh,neq,sum}
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h02, 3'b000}; // first check, sum_vld=0
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 8'h05, 3'b000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h02, 3'b001}; // sum_q=5 trips
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h10, 8'h11, 3'b010}; // a==b, one-hot ok
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h03, 3'b000}; // en=0 masks sum_q=0x11
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 8'h01, 3'b100}; // a=0 not one-hot
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 8'h04, 3'b100}; // sum_q=1 passes
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 8'h81, 3'b000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 3'b101}; // wrap
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h03, 3'b000}; // wrapped sum passes
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 8'h21, 3'b000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h02, 3'b011}; // clr with pulses
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 3'b110};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h04, 8'h00, 8'h05, 3'b000}; // clr, no pulses
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 8'h05, 3'b000};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 8'h05, 3'b001};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000}; // reset discards pulses
        vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h02, 3'b000};

        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 18; i++) apply(vecs[i], i);

        // Counter saturation with a=b=3 held.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        clr   = 1'b0;
        a     = 8'h03;
        b     = 8'h03;
        repeat (65535) @(posedge clk);
        #1;
        check("sat_cnt_neq",    32'(cnt_neq),    32'hFFFF);
        check("sat_cnt_onehot", 32'(cnt_onehot), 32'hFFFF);
        check("sat_cnt_sum",    32'(cnt_sum),    32'd0);
        check("sat_err_neq",    32'(err_neq),    32'd1);
        check("sat_sticky",     32'(sticky),     32'b110);
        $display("saturate: cnt_neq=%h cnt_onehot=%h sticky=%b", cnt_neq, cnt_onehot, sticky);
        repeat (5) @(posedge clk);
        #1;
        check("hold_cnt_neq",    32'(cnt_neq),    32'hFFFF);
        check("hold_cnt_onehot", 32'(cnt_onehot), 32'hFFFF);
        $display("hold: cnt_neq=%h cnt_onehot=%h", cnt_neq, cnt_onehot);

        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_cnt_neq",    32'(cnt_neq),    32'd1);
        check("clr_cnt_onehot", 32'(cnt_onehot), 32'd1);
        check("clr_sticky",     32'(sticky),     32'b110);
        check("clr_err_neq",    32'(err_neq),    32'd1);
        $display("clr: cnt_neq=%h cnt_onehot=%h sticky=%b", cnt_neq, cnt_onehot, sticky);

        @(negedge clk);
        clr   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
